// File: rtl/mmio_bridge_if.sv
// CPU-side memory-mapped bus between the proc core and mmio_bridge.
// The core drives address, write data and strobe; the bridge returns read data.
interface mmio_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_dout;
    logic        cpu_W;
    logic [31:0] cpu_din;

    modport master (output cpu_addr, cpu_dout, cpu_W, input cpu_din);
    modport slave  (input cpu_addr, cpu_dout, cpu_W, output cpu_din);
endinterface

// File: rtl/mmio_bridge.sv
// Memory-mapped bridge: decodes CPU accesses to RAM, LEDs, debounced switches
// and a free-running timer, with every read aligned to the RAM's one-cycle latency.
module mmio_bridge #(
    parameter int unsigned RAM_AW     = 16,
    parameter logic [31:0] LED_ADDR   = 32'h0000_000F,
    parameter logic [31:0] SW_ADDR    = 32'h0000_0010,
    parameter logic [31:0] TMR_ADDR   = 32'h0000_0011,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    mmio_bridge_if.slave      cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    input  logic [9:0]        sw_in,
    output logic [9:0]        led_out
);
    localparam int unsigned DW    = 32;
    localparam int unsigned SW_W  = 10;
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TMR,
        SEL_NONE
    } sel_e;

    sel_e             sel_c;
    sel_e             sel_q;
    logic [DW-1:0]    per_c;
    logic [DW-1:0]    per_q;
    logic [DW-1:0]    tmr;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [SW_W-1:0]  sw_stable;
    logic [CNT_W-1:0] deb_cnt;

    // Priority decode; peripheral addresses shadow the RAM region.
    always_comb begin
        sel_c = SEL_NONE;
        if (cpu.cpu_addr == LED_ADDR) begin
            sel_c = SEL_LED;
        end else if (cpu.cpu_addr == SW_ADDR) begin
            sel_c = SEL_SW;
        end else if (cpu.cpu_addr == TMR_ADDR) begin
            sel_c = SEL_TMR;
        end else if ((cpu.cpu_addr >> RAM_AW) == '0) begin
            sel_c = SEL_RAM;
        end
    end

    always_comb begin
        per_c = '0;
        case (sel_c)
            SEL_LED: per_c = DW'(led_out);
            SEL_SW:  per_c = DW'(sw_stable);
            SEL_TMR: per_c = tmr;
            default: per_c = '0;
        endcase
    end

    assign ram_addr    = cpu.cpu_addr[RAM_AW-1:0];
    assign ram_data    = cpu.cpu_dout;
    assign ram_wren    = cpu.cpu_W & (sel_c == SEL_RAM);
    assign cpu.cpu_din = (sel_q == SEL_RAM) ? ram_q : per_q;

    // Read-path alignment: peripheral data is registered to match RAM latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q <= SEL_NONE;
            per_q <= '0;
        end else begin
            sel_q <= sel_c;
            per_q <= per_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_out <= '0;
        end else if (cpu.cpu_W && (sel_c == SEL_LED)) begin
            led_out <= cpu.cpu_dout[SW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr <= '0;
        end else if (cpu.cpu_W && (sel_c == SEL_TMR)) begin
            tmr <= cpu.cpu_dout;
        end else begin
            tmr <= tmr + DW'(1);
        end
    end

    // Shared debounce counter: runs while any synchronized bit differs from the stable value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_stable <= '0;
            deb_cnt   <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (sw_sync == sw_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                sw_stable <= sw_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: stimulus queues expected values tagged with
// the cycle they are due, and a negedge monitor pops and compares them.
module tb_mmio_bridge;
    localparam int unsigned RAM_AW   = 16;
    localparam logic [31:0] LED_A    = 32'h0000_000F;
    localparam logic [31:0] SW_A     = 32'h0000_0010;
    localparam logic [31:0] TMR_A    = 32'h0000_0011;
    localparam int          S_DIN    = 0;
    localparam int          S_LED    = 1;
    localparam int          S_WREN   = 2;
    localparam int          S_RADDR  = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q = 32'h0;
    logic [9:0]        sw_in = 10'h0;
    logic [9:0]        led_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_bridge_if bus ();

    mmio_bridge #(
        .RAM_AW    (RAM_AW),
        .LED_ADDR  (LED_A),
        .SW_ADDR   (SW_A),
        .TMR_ADDR  (TMR_A),
        .DEB_CYCLES(4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .cpu     (bus.slave),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_wren(ram_wren),
        .ram_q   (ram_q),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    // Small synchronous RAM with one-cycle read latency (low address bits only).
    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        ram_q <= mem[ram_addr[7:0]];
        if (ram_wren) mem[ram_addr[7:0]] <= ram_data;
    end

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_DIN:   return bus.cpu_din;
            S_LED:   return 32'(led_out);
            S_WREN:  return 32'(ram_wren);
            default: return 32'(ram_addr);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [31:0] act;
                act = sample(sb[i].sig);
                checks++;
                if (sb[i].due < cyc || act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int due, input int sig, input logic [31:0] exp, input string name);
        exp_t e;
        e.due = due; e.sig = sig; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(posedge clk);
        #1;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.cpu_W    = w;
    endtask

    initial begin
        logic [31:0] tmr_exp [3];
        tmr_exp[0] = 32'hFFFF_FFFE;
        tmr_exp[1] = 32'hFFFF_FFFF;
        tmr_exp[2] = 32'h0000_0000;
        bus.cpu_addr = LED_A;
        bus.cpu_dout = 32'h3FF;
        bus.cpu_W    = 1'b1;

        // Reset held while writing LED and toggling switches.
        for (int k = 0; k < 4; k++) begin
            drive(LED_A, 32'h3FF, 1'b1);
            sw_in = (k % 2 == 1) ? 10'h3FF : 10'h155;
            expect_at(cyc, S_DIN, 32'h0, "rst_din");
            expect_at(cyc, S_LED, 32'h0, "rst_led");
            expect_at(cyc, S_WREN, 32'h0, "rst_wren");
        end
        drive(TMR_A, 32'h0, 1'b0);
        resetn = 1'b1;
        sw_in  = 10'h0;
        expect_at(cyc + 1, S_DIN, 32'h0, "tmr_first");
        drive(TMR_A, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'h1, "tmr_second");

        // LED write then read-back; upper data bits must be dropped.
        drive(LED_A, 32'hABCD_E3A5, 1'b1);
        expect_at(cyc, S_WREN, 32'h0, "led_wr_wren");
        drive(LED_A, 32'h0, 1'b0);
        expect_at(cyc, S_LED, 32'h3A5, "led_out");
        expect_at(cyc + 1, S_DIN, 32'h0000_03A5, "led_rd");

        // RAM write/read and an unmapped address just above the RAM region.
        drive(32'h20, 32'hCAFE_F00D, 1'b1);
        expect_at(cyc, S_WREN, 32'h1, "ram_wren");
        expect_at(cyc, S_RADDR, 32'h20, "ram_addr");
        drive(32'h20, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'hCAFE_F00D, "ram_rd");
        drive(32'h0001_0000, 32'h1234_5678, 1'b1);
        expect_at(cyc, S_WREN, 32'h0, "unmap_wren");
        drive(32'h0001_0000, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'h0, "unmap_rd");

        // Timer load and wrap.
        drive(TMR_A, 32'hFFFF_FFFE, 1'b1);
        expect_at(cyc, S_WREN, 32'h0, "tmr_wr_wren");
        for (int k = 0; k < 3; k++) begin
            drive(TMR_A, 32'h0, 1'b0);
            expect_at(cyc + 1, S_DIN, tmr_exp[k], "tmr_wrap");
        end

        // Three-cycle glitch must be rejected; writes to SW are ignored.
        for (int k = 0; k < 12; k++) begin
            drive(SW_A, 32'h3FF, (k % 2 == 0));
            sw_in = (k < 3) ? 10'h001 : 10'h000;
            expect_at(cyc + 1, S_DIN, 32'h0, "sw_glitch");
        end

        // Steady change appears in sw_stable exactly six edges later.
        for (int k = 0; k < 9; k++) begin
            drive(SW_A, 32'h0, 1'b0);
            if (k == 0) sw_in = 10'h201;
            expect_at(cyc + 1, S_DIN, (k >= 6) ? 32'h201 : 32'h0, "sw_debounce");
        end

        // Back-to-back reads across regions.
        drive(LED_A, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'h3A5, "b2b_led");
        drive(32'h20, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'hCAFE_F00D, "b2b_ram");
        drive(SW_A, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'h201, "b2b_sw");
        drive(32'h8000_0000, 32'h0, 1'b0);
        expect_at(cyc + 1, S_DIN, 32'h0, "b2b_unmap");

        // Reset mid-read clears the pending LED read immediately.
        drive(LED_A, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        expect_at(cyc, S_DIN, 32'h0, "rst_mid_din");
        expect_at(cyc, S_LED, 32'h0, "rst_mid_led");

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory-mapped I/O bridge between the `proc` core's bus (address, write data, write strobe, read data) and the on-chip RAM plus board peripherals. Decodes each CPU access to RAM, LED register, debounced switch register or free-running timer. Aligns all read data to the RAM's one-cycle read latency so the core sees a uniform read path. Sits directly downstream of `proc` and upstream of `RAM` and the board LEDs/switches.

## Interface
Parameters:
- `RAM_AW`, 16, RAM word-address width; RAM region is addresses 0 .. 2^RAM_AW-1.
- `LED_ADDR`, 32'h0000_000F, LED register address.
- `SW_ADDR`, 32'h0000_0010, switch register address (read-only).
- `TMR_ADDR`, 32'h0000_0011, timer register address.
- `DEB_CYCLES`, 16, consecutive stable cycles required to accept a switch change (≥1).

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `resetn` in 1: already decided; asynchronous, active-low reset.
- `cpu_addr` in 32: CPU address (`realaddr`).
- `cpu_dout` in 32: CPU write data.
- `cpu_W` in 1: CPU write strobe.
- `cpu_din` out 32: read data to CPU.
- `ram_addr` out RAM_AW: `cpu_addr[RAM_AW-1:0]`.
- `ram_data` out 32: equals `cpu_dout`.
- `ram_wren` out 1: RAM write enable.
- `ram_q` in 32: RAM read data, valid one cycle after address.
- `sw_in` in 10: raw asynchronous switches.
- `led_out` out 10: LED register.

## Operation
- Decode (combinational, priority): LED_ADDR → LED; SW_ADDR → SW; TMR_ADDR → TMR; else `cpu_addr < 2^RAM_AW` → RAM; else UNMAPPED.
- Peripheral addresses shadow RAM: `ram_wren = cpu_W & (sel==RAM)`; writes to LED/SW/TMR/UNMAPPED never reach RAM.
- LED: on edge with `cpu_W & sel==LED`, `led_out <= cpu_dout[9:0]`. Reads return `{22'b0, led_out}`.
- SW: `sw_in` through 2-flop synchronizer → `sw_sync`. Debounce counter per bus (shared): if `sw_sync != sw_stable`, counter increments; when counter reaches DEB_CYCLES-1 and still differing, `sw_stable <= sw_sync`, counter clears. Any cycle with `sw_sync == sw_stable` clears counter. A changed-but-different new value during counting restarts nothing (count continues while any difference persists). Writes ignored. Reads return `{22'b0, sw_stable}`.
- TMR: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF → 0. Write (`cpu_W & sel==TMR`) loads `cpu_dout` instead of incrementing. Read returns value held before that edge.
- Read path: every edge registers `sel_q <= sel` and `per_q <=` peripheral read value (0 for RAM/UNMAPPED). `cpu_din = (sel_q==RAM) ? ram_q : per_q`. UNMAPPED reads return 0. Writes also update `sel_q/per_q`; `cpu_din` after a write cycle is don't-care to the CPU but deterministic.

## Timing
- Reset (async assert, sync release): `led_out`=0, timer=0, sync flops=0, `sw_stable`=0, debounce counter=0, `sel_q`=UNMAPPED, `per_q`=0 → `cpu_din`=0. `ram_wren`=0 whenever `cpu_W`=0.
- Read latency: address in cycle N → `cpu_din` valid cycle N+1, all regions.
- Write takes effect at the edge ending cycle N; a read of the same register in cycle N+1 returns the new value.
- Timer: write 0x100 at edge k; read addressed in cycle k+1 returns 0x100; next cycle 0x101.
- Switch latency: raw change held steady → `sw_stable` updates 2+DEB_CYCLES edges later. Glitch shorter than DEB_CYCLES cycles (post-sync) never reaches `sw_stable`.
- Reset mid-operation: all state cleared immediately; pending read returns 0.

## Test plan
- Reset: hold `resetn`=0, toggle `sw_in`, `cpu_W`=1 at LED_ADDR → `led_out`=0, `cpu_din`=0, `ram_wren`=0; timer reads 0 in first cycle after release.
- LED: write 0x3A5 to 0xF, read 0xF next cycle → `cpu_din`=0x0000_03A5, `led_out`=0x3A5, `ram_wren` never asserted.
- RAM: write 0xCAFE_F00D to 0x20 (`ram_wren`=1, `ram_addr`=0x20); read 0x20 → `cpu_din`=0xCAFE_F00D one cycle later; address 0x1_0000 read → 0.
- Timer: write 0xFFFF_FFFE, read 3 consecutive cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Debounce (DEB_CYCLES=4): `sw_in`=0x001 for 3 cycles then back → SW read stays 0; hold 0x201 → SW reads 0x201 exactly 6 edges after change.
- Back-to-back: read LED, read RAM, read SW on consecutive cycles → `cpu_din` returns each value in order, one cycle delayed.
